// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the ex stage.
// One quotient bit per cycle. The result is {remainder, quotient} for the HI/LO path.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 signed_div,
   input  logic [WIDTH-1:0]     opdata1,
   input  logic [WIDTH-1:0]     opdata2,
   input  logic                 start,
   input  logic                 annul,
   output logic [2*WIDTH-1:0]   result,
   output logic                 ready
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] partial_rem;
   logic [WIDTH-1:0] quotient;
   logic             sign1;
   logic             sign2;
   logic             signed_l;

   logic [WIDTH-1:0] abs1;
   logic [WIDTH-1:0] abs2;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   // Trial subtract is one bit wider than the remainder, so its MSB is the borrow.
   always_comb begin
      abs1    = (signed_div && opdata1[WIDTH-1]) ? WIDTH'(-opdata1) : opdata1;
      abs2    = (signed_div && opdata2[WIDTH-1]) ? WIDTH'(-opdata2) : opdata2;
      trial   = {partial_rem, dividend[WIDTH-1]} - {1'b0, divisor};
      quo_fix = (signed_l && (sign1 ^ sign2)) ? WIDTH'(-quotient) : quotient;
      rem_fix = (signed_l && sign1) ? WIDTH'(-partial_rem) : partial_rem;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         dividend    <= '0;
         divisor     <= '0;
         partial_rem <= '0;
         quotient    <= '0;
         sign1       <= 1'b0;
         sign2       <= 1'b0;
         signed_l    <= 1'b0;
         result      <= '0;
         ready       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ready  <= 1'b0;
               result <= '0;
               if (start && !annul) begin
                  dividend    <= abs1;
                  divisor     <= abs2;
                  partial_rem <= '0;
                  quotient    <= '0;
                  sign1       <= opdata1[WIDTH-1];
                  sign2       <= opdata2[WIDTH-1];
                  signed_l    <= signed_div;
                  cnt         <= '0;
                  state       <= (opdata2 == '0) ? BYZERO : ON;
               end
            end
            BYZERO: begin
               result <= '0;
               state  <= annul ? IDLE : END;
            end
            ON: begin
               if (annul) begin
                  state <= IDLE;
               end else if (cnt == CW'(WIDTH)) begin
                  result <= {rem_fix, quo_fix};
                  ready  <= 1'b1;
                  state  <= END;
               end else begin
                  // Keep the difference when no borrow, otherwise restore.
                  if (!trial[WIDTH]) begin
                     partial_rem <= trial[WIDTH-1:0];
                  end else begin
                     partial_rem <= {partial_rem[WIDTH-2:0], dividend[WIDTH-1]};
                  end
                  quotient <= {quotient[WIDTH-2:0], ~trial[WIDTH]};
                  dividend <= {dividend[WIDTH-2:0], 1'b0};
                  cnt      <= cnt + CW'(1);
               end
            end
            END: begin
               if (!start) begin
                  state  <= IDLE;
                  ready  <= 1'b0;
                  result <= '0;
               end else begin
                  ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: cycle-level behavioural model with a per-cycle compare,
// directed corner cases and randomized divides.
`timescale 1ns/1ps
module tb_div_unit;

   localparam int unsigned WIDTH = 32;

   logic                clk = 1'b0;
   logic                reset;
   logic                signed_div;
   logic [WIDTH-1:0]    opdata1;
   logic [WIDTH-1:0]    opdata2;
   logic                start;
   logic                annul;
   logic [2*WIDTH-1:0]  result;
   logic                ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_unit #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .signed_div(signed_div),
      .opdata1(opdata1), .opdata2(opdata2), .start(start),
      .annul(annul), .result(result), .ready(ready)
   );

   // Reference arithmetic: truncating division, remainder takes dividend's sign.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      longint x, y, q, r;
      if (b == 32'h0) return 64'h0;
      if (s) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = longint'({32'h0, a});
         y = longint'({32'h0, b});
      end
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: edges since acceptance, edge at which END is reached, edge at which ready shows.
   bit          m_busy = 1'b0;
   int          m_n = 0;
   int          m_end = 0;
   int          m_rdy = 0;
   logic [63:0] m_val = 64'h0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 1'b0;
         m_n    = 0;
      end else if (!m_busy) begin
         if (start && !annul) begin
            m_busy = 1'b1;
            m_n    = 0;
            if (opdata2 == 32'h0) begin
               m_end = 1;
               m_rdy = 2;
               m_val = 64'h0;
            end else begin
               m_end = WIDTH + 1;
               m_rdy = WIDTH + 1;
               m_val = ref_div(opdata1, opdata2, signed_div);
            end
         end
      end else if (m_n >= m_end) begin
         if (!start) m_busy = 1'b0;
         else if (m_n < 1000) m_n++;
      end else if (annul) begin
         m_busy = 1'b0;
      end else begin
         m_n++;
      end
   end

   always @(negedge clk) begin
      logic        exp_r;
      logic [63:0] exp_v;
      exp_r = m_busy && (m_n >= m_rdy);
      exp_v = exp_r ? m_val : 64'h0;
      check("ready", 64'(ready), 64'(exp_r));
      check("result", result, exp_v);
   end

   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(negedge clk);
      opdata1 = a; opdata2 = b; signed_div = s; start = 1'b1; annul = 1'b0;
   endtask

   task automatic wait_ready(input bit scramble, output logic [63:0] res, output int edges);
      edges = -1;
      res   = 64'h0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (scramble) begin
            opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
         end
         if (ready) begin
            res = result;
            break;
         end
      end
      check("ready_timeout", 64'(ready), 64'h1);
   endtask

   // Hold start a little longer (with ignored annul pulses), then drop it.
   task automatic release_start();
      repeat ($urandom_range(0, 2)) begin
         annul = 1'($urandom);
         @(negedge clk);
         annul = 1'b0;
      end
      start = 1'b0;
      annul = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
   endtask

   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [63:0] res, output int edges);
      launch(a, b, s);
      wait_ready(1'b1, res, edges);
      release_start();
   endtask

   logic [63:0] res;
   int          edges;
   logic [31:0] ra, rb;

   initial begin
      reset = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
      opdata1 = '0; opdata2 = '0;

      // Pin the reference model to hand-computed values.
      check("model_divu_100_7", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
      check("model_div_m7_2", ref_div(32'hFFFFFFF9, 32'd2, 1'b1), {32'hFFFFFFFF, 32'hFFFFFFFD});
      check("model_div_7_m2", ref_div(32'd7, 32'hFFFFFFFE, 1'b1), {32'd1, 32'hFFFFFFFD});
      check("model_div_min_m1", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'h0, 32'h80000000});

      repeat (3) @(negedge clk);
      check("reset_ready", 64'(ready), 64'h0);
      check("reset_result", result, 64'h0);
      reset = 1'b0;

      run_div(32'd100, 32'd7, 1'b0, res, edges);
      check("divu_100_7", res, {32'd2, 32'd14});
      check("divu_latency", 64'(edges), 64'd33);
      run_div(32'hFFFFFFF9, 32'd2, 1'b1, res, edges);
      check("div_m7_2", res, {32'hFFFFFFFF, 32'hFFFFFFFD});
      run_div(32'd7, 32'hFFFFFFFE, 1'b1, res, edges);
      check("div_7_m2", res, {32'd1, 32'hFFFFFFFD});
      run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, res, edges);
      check("div_min_m1", res, {32'h0, 32'h80000000});
      run_div(32'hFFFFFFFF, 32'd1, 1'b0, res, edges);
      check("divu_max_1", res, {32'h0, 32'hFFFFFFFF});
      run_div(32'd5, 32'd9, 1'b0, res, edges);
      check("divu_small", res, {32'd5, 32'd0});
      run_div(32'd1234, 32'd0, 1'b1, res, edges);
      check("byzero_result", res, 64'h0);
      check("byzero_latency", 64'(edges), 64'd2);

      // Abort at iteration 10, then an immediate new request with start held.
      launch(32'd100, 32'd7, 1'b0);
      repeat (11) @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0; opdata1 = 32'd9; opdata2 = 32'd3;
      wait_ready(1'b0, res, edges);
      check("after_annul", res, {32'd0, 32'd3});
      check("after_annul_latency", 64'(edges), 64'd33);
      release_start();

      // Reset at iteration 20, off the clock edge.
      launch(32'd100, 32'd7, 1'b0);
      repeat (21) @(posedge clk);
      #2 reset = 1'b1;
      #1 check("midrst_ready", 64'(ready), 64'h0);
      check("midrst_result", result, 64'h0);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      run_div(32'd5, 32'd5, 1'b0, res, edges);
      check("after_reset", res, {32'd0, 32'd1});

      // Reset while a result is being held clears it immediately.
      launch(32'd100, 32'd7, 1'b0);
      wait_ready(1'b0, res, edges);
      #2 reset = 1'b1;
      #1 check("endrst_ready", 64'(ready), 64'h0);
      check("endrst_result", result, 64'h0);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Randomized divides; the per-cycle compare checks every one.
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 3))
            0: ra = $urandom_range(0, 1000);
            1: ra = 32'h80000000;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = 32'h0;
            1: rb = 32'hFFFFFFFF;
            2: rb = $urandom_range(1, 20);
            3: rb = -$urandom_range(1, 20);
            default: rb = $urandom;
         endcase
         run_div(ra, rb, 1'($urandom), res, edges);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
